// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_stage_pkg
// Brief  : Types and constants shared by the memory stage and its aligner.
// Rev    : 1.0
// ============================================================================
package mem_stage_pkg;

    localparam int CORE_XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } mem_state_e;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_type_e;

    localparam logic [2:0] MEM_B  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_W  = 3'd2;
    localparam logic [2:0] MEM_D  = 3'd3;
    localparam logic [2:0] MEM_BU = 3'd4;
    localparam logic [2:0] MEM_HU = 3'd5;
    localparam logic [2:0] MEM_WU = 3'd6;

    localparam logic [CORE_XLEN-1:0] CAUSE_LOAD_MISALIGNED  = CORE_XLEN'(4);
    localparam logic [CORE_XLEN-1:0] CAUSE_STORE_MISALIGNED = CORE_XLEN'(6);

    typedef struct packed {
        mem_type_e              mem_type;
        logic [2:0]             funct3;
        logic                   expt_valid;
        logic [CORE_XLEN-1:0]   expt_cause;
        logic [11:0]            csr_addr;
        logic [1:0]             reg_wb_src;
        logic [CORE_XLEN-1:0]   inst_imm;
        logic [CORE_XLEN-1:0]   inst_pc;
        logic [CORE_XLEN-1:0]   alu_res;
        logic [CORE_XLEN-1:0]   rs2_data;
        logic [4:0]             rd_addr;
    } exmem_reg_t;

    typedef struct packed {
        logic [1:0]             reg_wb_src;
        logic [CORE_XLEN-1:0]   inst_imm;
        logic [CORE_XLEN-1:0]   inst_pc;
        logic [CORE_XLEN-1:0]   alu_res;
        logic [4:0]             rd_addr;
        logic [CORE_XLEN-1:0]   load_data;
        logic [CORE_XLEN-1:0]   csr_rd_data;
        logic                   raise_trap;
        logic [CORE_XLEN-1:0]   trap_cause;
    } memwb_reg_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_align.sv
`default_nettype none
// ============================================================================
// Module : mem_stage_align
// Brief  : Byte-lane alignment for stores, load extraction/extension, misalignment.
// Rev    : 1.0
// ============================================================================
module mem_stage_align
    import mem_stage_pkg::*;
#(
    parameter  int XLEN   = CORE_XLEN,
    localparam int OFF_W  = $clog2(XLEN/8),
    localparam int MASK_W = XLEN/8
) (
    input  logic [2:0]        funct3,
    input  logic [OFF_W-1:0]  off,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [MASK_W-1:0] wmask,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned
);

    logic [MASK_W-1:0] w_size_mask;
    logic [XLEN-1:0]   w_shifted;

    // funct3[1:0] encodes access size for both signed and unsigned variants
    always_comb begin
        w_size_mask = '0;
        misaligned  = 1'b0;
        case (funct3[1:0])
            2'd0: w_size_mask = MASK_W'(8'h01);
            2'd1: begin
                w_size_mask = MASK_W'(8'h03);
                misaligned  = off[0];
            end
            2'd2: begin
                w_size_mask = MASK_W'(8'h0F);
                misaligned  = |off[1:0];
            end
            default: begin
                w_size_mask = '1;
                misaligned  = |off;
            end
        endcase
    end

    assign wmask     = w_size_mask << off;
    assign wdata     = rs2_data << {off, 3'b000};
    assign w_shifted = rdata >> {off, 3'b000};

    always_comb begin
        load_data = w_shifted;
        case (funct3)
            MEM_B:   load_data = XLEN'($signed(w_shifted[7:0]));
            MEM_H:   load_data = XLEN'($signed(w_shifted[15:0]));
            MEM_W:   load_data = XLEN'($signed(w_shifted[31:0]));
            MEM_BU:  load_data = XLEN'(w_shifted[7:0]);
            MEM_HU:  load_data = XLEN'(w_shifted[15:0]);
            MEM_WU:  load_data = XLEN'(w_shifted[31:0]);
            default: load_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_stage
// Brief  : Pipeline memory stage: data-memory handshake, load/store alignment, MEM->WB register.
// Rev    : 1.0
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = CORE_XLEN
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           ex_valid_i,
    output logic                           ex_ready_o,
    input  logic [$bits(exmem_reg_t)-1:0]  exmem_i,
    input  logic [XLEN-1:0]                csr_rd_data_i,
    output logic                           dmem_req_valid_o,
    input  logic                           dmem_req_ready_i,
    output logic [XLEN-1:0]                dmem_addr_o,
    output logic                           dmem_we_o,
    output logic [XLEN/8-1:0]              dmem_wmask_o,
    output logic [XLEN-1:0]                dmem_wdata_o,
    input  logic                           dmem_resp_valid_i,
    input  logic [XLEN-1:0]                dmem_rdata_i,
    output logic                           wb_valid_o,
    output logic [$bits(memwb_reg_t)-1:0]  memwb_o
);

    localparam int OFF_W = $clog2(XLEN/8);

    exmem_reg_t        w_ex;
    mem_state_e        r_state;
    exmem_reg_t        r_op;
    logic [XLEN-1:0]   r_csr;
    logic [XLEN/8-1:0] r_wmask;
    logic [XLEN-1:0]   r_wdata;
    logic              r_wb_valid;
    memwb_reg_t        r_memwb;

    logic [2:0]        w_funct3;
    logic [OFF_W-1:0]  w_off;
    logic [XLEN/8-1:0] w_wmask;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_load_data;
    logic              w_misaligned;
    logic              w_is_mem;
    logic              w_bypass;
    memwb_reg_t        w_direct_wb;
    memwb_reg_t        w_resp_wb;
    logic              w_unused;

    assign w_ex = exmem_reg_t'(exmem_i);

    // In IDLE the aligner checks the incoming op; afterwards it serves the latched op's response
    assign w_funct3 = (r_state == S_IDLE) ? w_ex.funct3 : r_op.funct3;
    assign w_off    = (r_state == S_IDLE) ? w_ex.alu_res[OFF_W-1:0] : r_op.alu_res[OFF_W-1:0];

    mem_stage_align #(.XLEN(XLEN)) u_align (
        .funct3     (w_funct3),
        .off        (w_off),
        .rs2_data   (w_ex.rs2_data),
        .rdata      (dmem_rdata_i),
        .wmask      (w_wmask),
        .wdata      (w_wdata),
        .load_data  (w_load_data),
        .misaligned (w_misaligned)
    );

    assign w_is_mem = (w_ex.mem_type == MEM_LOAD) || (w_ex.mem_type == MEM_STORE);
    assign w_bypass = !w_is_mem || w_ex.expt_valid || w_misaligned;

    always_comb begin
        w_direct_wb             = '0;
        w_direct_wb.reg_wb_src  = w_ex.reg_wb_src;
        w_direct_wb.inst_imm    = w_ex.inst_imm;
        w_direct_wb.inst_pc     = w_ex.inst_pc;
        w_direct_wb.alu_res     = w_ex.alu_res;
        w_direct_wb.rd_addr     = w_ex.rd_addr;
        w_direct_wb.csr_rd_data = csr_rd_data_i;
        if (w_ex.expt_valid) begin
            w_direct_wb.raise_trap = 1'b1;
            w_direct_wb.trap_cause = w_ex.expt_cause;
        end else if (w_is_mem && w_misaligned) begin
            w_direct_wb.raise_trap = 1'b1;
            w_direct_wb.trap_cause = (w_ex.mem_type == MEM_STORE) ? CAUSE_STORE_MISALIGNED
                                                                  : CAUSE_LOAD_MISALIGNED;
        end

        w_resp_wb             = '0;
        w_resp_wb.reg_wb_src  = r_op.reg_wb_src;
        w_resp_wb.inst_imm    = r_op.inst_imm;
        w_resp_wb.inst_pc     = r_op.inst_pc;
        w_resp_wb.alu_res     = r_op.alu_res;
        w_resp_wb.rd_addr     = r_op.rd_addr;
        w_resp_wb.csr_rd_data = r_csr;
        w_resp_wb.load_data   = (r_op.mem_type == MEM_LOAD) ? w_load_data : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_csr      <= '0;
            r_wmask    <= '0;
            r_wdata    <= '0;
            r_wb_valid <= 1'b0;
            r_memwb    <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_valid_i && !flush_i) begin
                        if (w_bypass) begin
                            r_memwb    <= w_direct_wb;
                            r_wb_valid <= 1'b1;
                        end else begin
                            r_op    <= w_ex;
                            r_csr   <= csr_rd_data_i;
                            r_wmask <= w_wmask;
                            r_wdata <= w_wdata;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A flush coinciding with acceptance still owes us a response, so drain it
                    if (flush_i)
                        r_state <= dmem_req_ready_i ? S_DRAIN : S_IDLE;
                    else if (dmem_req_ready_i)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (flush_i) begin
                        r_state <= dmem_resp_valid_i ? S_IDLE : S_DRAIN;
                    end else if (dmem_resp_valid_i) begin
                        r_memwb    <= w_resp_wb;
                        r_wb_valid <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (dmem_resp_valid_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ex_ready_o       = (r_state == S_IDLE);
    assign dmem_req_valid_o = (r_state == S_REQ);
    assign dmem_addr_o      = {r_op.alu_res[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign dmem_we_o        = (r_op.mem_type == MEM_STORE);
    assign dmem_wmask_o     = r_wmask;
    assign dmem_wdata_o     = r_wdata;
    assign wb_valid_o       = r_wb_valid;
    assign memwb_o          = r_memwb;

    assign w_unused = ^{w_ex.csr_addr, r_op.expt_valid, r_op.expt_cause, r_op.csr_addr,
                        r_op.rs2_data};

endmodule
`default_nettype wire
